// File: rtl/watch_pkg.sv
// Shared watch definitions: stopwatch state encoding, BCD digit limits and time payload.
package watch_pkg;

   localparam int unsigned TIME_W    = 16;
   localparam int unsigned SEC_T_MAX = 5;
   localparam int unsigned U_MAX     = 9;
   localparam int unsigned MIN_T_MAX = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSE  = 2'd2,
      RECALL = 2'd3
   } sw_state_t;

   typedef struct packed {
      logic [3:0] mm_t;
      logic [3:0] mm_u;
      logic [3:0] ss_t;
      logic [3:0] ss_u;
   } bcd_time_t;

   function automatic logic is_max_time(input bcd_time_t t);
      return (t.mm_t == 4'(MIN_T_MAX)) && (t.mm_u == 4'(U_MAX)) &&
             (t.ss_t == 4'(SEC_T_MAX)) && (t.ss_u == 4'(U_MAX));
   endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// BCD MM:SS counter; clr beats en, wrap_c flags the 59:59 -> 00:00 step.
module bcd_mmss_counter
   import watch_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      clr,
   input  logic      en,
   output bcd_time_t count,
   output logic      wrap_c
);

   bcd_time_t count_nxt;

   always_comb begin
      count_nxt = count;
      wrap_c    = 1'b0;
      if (clr) begin
         count_nxt = '0;
      end else if (en) begin
         if (count.ss_u != 4'(U_MAX)) begin
            count_nxt.ss_u = count.ss_u + 4'd1;
         end else begin
            count_nxt.ss_u = '0;
            if (count.ss_t != 4'(SEC_T_MAX)) begin
               count_nxt.ss_t = count.ss_t + 4'd1;
            end else begin
               count_nxt.ss_t = '0;
               if (count.mm_u != 4'(U_MAX)) begin
                  count_nxt.mm_u = count.mm_u + 4'd1;
               end else begin
                  count_nxt.mm_u = '0;
                  if (count.mm_t != 4'(MIN_T_MAX)) begin
                     count_nxt.mm_t = count.mm_t + 4'd1;
                  end else begin
                     count_nxt.mm_t = '0;
                     wrap_c         = 1'b1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) count <= '0;
      else      count <= count_nxt;
   end

endmodule

// File: rtl/sw_lap_recorder.sv
// Stopwatch with circular lap memory and recall onto the shared digit bus.
// Define SW_LAP_DELTA_EN to store per-lap durations instead of cumulative splits.
module sw_lap_recorder
   import watch_pkg::*;
#(
   parameter  int unsigned LAP_DEPTH = 8,
   localparam int unsigned AW        = $clog2(LAP_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en_sec,
   input  logic          start_stop_btn,
   input  logic          lap_btn,
   input  logic          recall_btn,
   output logic [3:0]    mm_t_out,
   output logic [3:0]    mm_u_out,
   output logic [3:0]    ss_t_out,
   output logic [3:0]    ss_u_out,
   output logic [AW-1:0] lap_idx,
   output logic [AW:0]   lap_count,
   output logic          recall_active,
   output logic          ovf
);

   localparam int unsigned CW = AW + 1;

   sw_state_t       state, state_nxt;
   sw_state_t       ret_state, ret_state_nxt;
   logic [AW-1:0]   idx_q, idx_nxt;
   logic [CW-1:0]   lap_cnt_q, lap_cnt_nxt;
   logic [AW-1:0]   wr_ptr, wr_ptr_nxt;
   logic            ovf_q, ovf_nxt;

   logic            cnt_en, cnt_clr, wr_en, ovf_clr;
   logic [CW-1:0]   idx_inc;
   logic [AW-1:0]   rd_addr;
   bcd_time_t       count, wr_data, disp;
   logic            wrap_main_c, wrap_any_c;

   logic [TIME_W-1:0] mem [LAP_DEPTH];

   bcd_mmss_counter u_main (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .count  (count),
      .wrap_c (wrap_main_c)
   );

`ifdef SW_LAP_DELTA_EN
   bcd_time_t delta;
   logic      wrap_delta_c;

   // Delta restarts at every effective lap press and every clear.
   bcd_mmss_counter u_delta (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr | wr_en),
      .en     (cnt_en),
      .count  (delta),
      .wrap_c (wrap_delta_c)
   );

   assign wr_data    = delta;
   assign wrap_any_c = wrap_main_c | wrap_delta_c;
`else
   assign wr_data    = count;
   assign wrap_any_c = wrap_main_c;
`endif

   assign idx_inc = CW'(idx_q) + CW'(1);
   assign rd_addr = wr_ptr - AW'(1) - idx_q;

   // Next-state and control; button priority start_stop > lap > recall.
   always_comb begin
      state_nxt     = state;
      ret_state_nxt = ret_state;
      idx_nxt       = idx_q;
      cnt_en        = 1'b0;
      cnt_clr       = 1'b0;
      wr_en         = 1'b0;
      ovf_clr       = 1'b0;
      lap_cnt_nxt   = lap_cnt_q;
      wr_ptr_nxt    = wr_ptr;
      ovf_nxt       = ovf_q;

      case (state)
         IDLE: begin
            if (start_stop_btn) begin
               state_nxt = RUN;
            end else if (lap_btn) begin
               cnt_clr = 1'b1;
            end else if (recall_btn && (lap_cnt_q != '0)) begin
               state_nxt     = RECALL;
               ret_state_nxt = IDLE;
               idx_nxt       = '0;
            end
         end
         RUN: begin
            cnt_en = en_sec;
            if (start_stop_btn) state_nxt = PAUSE;
            else if (lap_btn)   wr_en     = 1'b1;
         end
         PAUSE: begin
            if (start_stop_btn) begin
               state_nxt = RUN;
            end else if (lap_btn) begin
               cnt_clr   = 1'b1;
               ovf_clr   = 1'b1;
               state_nxt = IDLE;
            end else if (recall_btn && (lap_cnt_q != '0)) begin
               state_nxt     = RECALL;
               ret_state_nxt = PAUSE;
               idx_nxt       = '0;
            end
         end
         RECALL: begin
            if (start_stop_btn) begin
               state_nxt = ret_state;
            end else if (recall_btn) begin
               idx_nxt = (idx_inc >= lap_cnt_q) ? '0 : AW'(idx_inc);
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (cnt_clr) begin
         lap_cnt_nxt = '0;
         wr_ptr_nxt  = '0;
      end else if (wr_en) begin
         wr_ptr_nxt = wr_ptr + AW'(1);
         if (lap_cnt_q != CW'(LAP_DEPTH)) lap_cnt_nxt = lap_cnt_q + CW'(1);
      end

      if (ovf_clr)         ovf_nxt = 1'b0;
      else if (wrap_any_c) ovf_nxt = 1'b1;
   end

   // Display source: recalled entry in RECALL, live count otherwise.
   always_comb begin
      disp = count;
      if (state == RECALL) disp = bcd_time_t'(mem[rd_addr]);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         ret_state     <= IDLE;
         idx_q         <= '0;
         lap_cnt_q     <= '0;
         wr_ptr        <= '0;
         ovf_q         <= 1'b0;
         mm_t_out      <= '0;
         mm_u_out      <= '0;
         ss_t_out      <= '0;
         ss_u_out      <= '0;
         lap_idx       <= '0;
         lap_count     <= '0;
         recall_active <= 1'b0;
         ovf           <= 1'b0;
      end else begin
         state         <= state_nxt;
         ret_state     <= ret_state_nxt;
         idx_q         <= idx_nxt;
         lap_cnt_q     <= lap_cnt_nxt;
         wr_ptr        <= wr_ptr_nxt;
         ovf_q         <= ovf_nxt;
         mm_t_out      <= disp.mm_t;
         mm_u_out      <= disp.mm_u;
         ss_t_out      <= disp.ss_t;
         ss_u_out      <= disp.ss_u;
         lap_idx       <= idx_q;
         lap_count     <= lap_cnt_q;
         recall_active <= (state == RECALL);
         ovf           <= ovf_q;
      end
   end

   // Lap memory has no reset; reset only blocks a write in flight.
   always_ff @(posedge clk) begin
      if (rst && wr_en) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: tb/tb_sw_lap_recorder.sv
// Directed self-checking bench for sw_lap_recorder (LAP_DEPTH=8).
module tb_sw_lap_recorder;
   import watch_pkg::*;

   localparam int unsigned AW = 3;

`ifdef SW_LAP_DELTA_EN
   localparam logic [15:0] E_R0 = 16'h0015, E_R1 = 16'h0015, E_R2 = 16'h0010;
   localparam logic [15:0] E_OLD = 16'h0001, E_NEW = 16'h0001;
`else
   localparam logic [15:0] E_R0 = 16'h0040, E_R1 = 16'h0025, E_R2 = 16'h0010;
   localparam logic [15:0] E_OLD = 16'h0003, E_NEW = 16'h0010;
`endif

   logic          clk = 1'b0;
   logic          rst, en_sec, start_stop_btn, lap_btn, recall_btn;
   logic [3:0]    mm_t_out, mm_u_out, ss_t_out, ss_u_out;
   logic [AW-1:0] lap_idx;
   logic [AW:0]   lap_count;
   logic          recall_active, ovf;

   int n_cmp = 0;
   int n_err = 0;

   sw_lap_recorder #(.LAP_DEPTH(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .en_sec         (en_sec),
      .start_stop_btn (start_stop_btn),
      .lap_btn        (lap_btn),
      .recall_btn     (recall_btn),
      .mm_t_out       (mm_t_out),
      .mm_u_out       (mm_u_out),
      .ss_t_out       (ss_t_out),
      .ss_u_out       (ss_u_out),
      .lap_idx        (lap_idx),
      .lap_count      (lap_count),
      .recall_active  (recall_active),
      .ovf            (ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] disp();
      return {mm_t_out, mm_u_out, ss_t_out, ss_u_out};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic ss, input logic lp, input logic rc, input logic es);
      start_stop_btn = ss;
      lap_btn        = lp;
      recall_btn     = rc;
      en_sec         = es;
      tick();
      start_stop_btn = 1'b0;
      lap_btn        = 1'b0;
      recall_btn     = 1'b0;
      en_sec         = 1'b0;
   endtask

   task automatic secs(input int n);
      en_sec = 1'b1;
      repeat (n) tick();
      en_sec = 1'b0;
   endtask

   initial begin
      rst = 1'b0; en_sec = 1'b0; start_stop_btn = 1'b0; lap_btn = 1'b0; recall_btn = 1'b0;
      tick(); tick();
      chk("rst_disp", 32'(disp()), 32'h0);
      chk("rst_idx", 32'(lap_idx), 32'd0);
      chk("rst_cnt", 32'(lap_count), 32'd0);
      chk("rst_rec", 32'(recall_active), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b1;
      tick();

      // 75 seconds then stop
      press(1, 0, 0, 0);
      secs(75);
      press(1, 0, 0, 0);
      tick();
      chk("t75_disp", 32'(disp()), 32'h0115);
      chk("t75_state", 32'(dut.state), 32'(PAUSE));
      chk("t75_ovf", 32'(ovf), 32'd0);

      // clear, then three laps
      press(0, 1, 0, 0);
      tick();
      chk("clr_disp", 32'(disp()), 32'h0);
      chk("clr_state", 32'(dut.state), 32'(IDLE));
      press(1, 0, 0, 0);
      secs(10); press(0, 1, 0, 0);
      secs(15); press(0, 1, 0, 0);
      secs(15); press(0, 1, 0, 0);
      press(1, 0, 0, 0);
      tick();
      chk("l3_cnt", 32'(lap_count), 32'd3);
      press(0, 0, 1, 0); tick();
      chk("r0_act", 32'(recall_active), 32'd1);
      chk("r0_idx", 32'(lap_idx), 32'd0);
      chk("r0_disp", 32'(disp()), 32'(E_R0));
      press(0, 0, 1, 0); tick();
      chk("r1_idx", 32'(lap_idx), 32'd1);
      chk("r1_disp", 32'(disp()), 32'(E_R1));
      press(0, 0, 1, 0); tick();
      chk("r2_idx", 32'(lap_idx), 32'd2);
      chk("r2_disp", 32'(disp()), 32'(E_R2));
      press(0, 0, 1, 0); tick();
      chk("r3_idx", 32'(lap_idx), 32'd0);
      chk("r3_disp", 32'(disp()), 32'(E_R0));
      press(0, 1, 0, 0); tick();
      chk("rlap_ign", 32'(lap_count), 32'd3);
      press(1, 0, 0, 0); tick();
      chk("ret_act", 32'(recall_active), 32'd0);
      chk("ret_state", 32'(dut.state), 32'(PAUSE));
      secs(3); tick();
      chk("pause_hold", 32'(disp()), 32'h0040);

      // ten laps into an eight-entry buffer
      press(0, 1, 0, 0);
      press(1, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         secs(1);
         press(0, 1, 0, 0);
      end
      press(1, 0, 0, 0);
      tick();
      chk("full_cnt", 32'(lap_count), 32'd8);
      press(0, 0, 1, 0); tick();
      chk("full_new", 32'(disp()), 32'(E_NEW));
      for (int i = 0; i < 7; i++) press(0, 0, 1, 0);
      tick();
      chk("full_idx7", 32'(lap_idx), 32'd7);
      chk("full_old", 32'(disp()), 32'(E_OLD));
      press(1, 0, 0, 0);

      // overflow from 59:59
      press(0, 1, 0, 0);
      press(1, 0, 0, 0);
      secs(3599);
      tick();
      chk("max_disp", 32'(disp()), 32'h5959);
      chk("max_ovf", 32'(ovf), 32'd0);
      secs(1);
      press(1, 0, 0, 0);
      tick();
      chk("wrap_disp", 32'(disp()), 32'h0000);
      chk("wrap_ovf", 32'(ovf), 32'd1);
      press(0, 1, 0, 0); tick();
      chk("pclr_ovf", 32'(ovf), 32'd0);
      chk("pclr_cnt", 32'(lap_count), 32'd0);
      chk("pclr_state", 32'(dut.state), 32'(IDLE));

      // start_stop + lap + en_sec together in RUN
      press(1, 0, 0, 0);
      secs(5);
      press(1, 1, 0, 1);
      tick();
      chk("co_state", 32'(dut.state), 32'(PAUSE));
      chk("co_cnt", 32'(lap_count), 32'd0);
      chk("co_disp", 32'(disp()), 32'h0006);

      // reset in the middle of RECALL
      press(1, 0, 0, 0);
      press(0, 1, 0, 0);
      press(1, 0, 0, 0);
      press(0, 0, 1, 0); tick();
      chk("pre_rst_act", 32'(recall_active), 32'd1);
      rst = 1'b0;
      tick();
      chk("mrst_disp", 32'(disp()), 32'h0);
      chk("mrst_act", 32'(recall_active), 32'd0);
      chk("mrst_cnt", 32'(lap_count), 32'd0);
      chk("mrst_state", 32'(dut.state), 32'(IDLE));
      rst = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
